// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes and an iterative mul/div engine
module alu_seq #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [6:0]   op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out,
  output logic [n-1:0] out_hi,
  output logic         cout,
  output logic         overflow,
  output logic         sign,
  output logic         zero,
  output logic         div_zero
);
  localparam int cw = $clog2(n);
  localparam logic [n-1:0] n_val = n'(n);
  localparam logic [cw-1:0] last_cnt = cw'(n - 1);
  typedef enum logic [1:0] {st_idle, st_busy, st_done} state_t;
  state_t st;
  logic [cw-1:0] cnt;
  logic [3:0] f_r;
  logic inv_r, neg_r;
  logic [n-1:0] acc, q, d;
  logic [3:0] f;
  logic take, iter, in_mul;
  logic [n-1:0] ma, mb;
  logic [n-1:0] x, y, bb, asr, rot, rol, ror, s_lo, s_hi, s_out;
  logic [n:0] sum;
  logic big, s_c, s_v, s_dz, s_zero;
  logic [n:0] msum, t;
  logic [n-1:0] td, nacc, nq, f_lo, f_hi, f_out;
  logic [2*n-1:0] prod;
  logic ge, is_mul, f_v;
  assign f = op[3:0];
  assign in_ready = (st == st_idle) | ((st == st_done) & out_ready);
  assign take = in_valid & in_ready;
  assign in_mul = (f == 4'd7) | (f == 4'd8);
  assign iter = in_mul | (((f == 4'd13) | (f == 4'd14)) & (|b));
  // signed multiply runs on magnitudes; the sign is restored after the last step
  always_comb begin
    ma = ((f == 4'd8) & a[n-1]) ? -a : a;
    mb = ((f == 4'd8) & b[n-1]) ? -b : b;
  end
  // single-cycle result from the operands presented at acceptance
  always_comb begin
    x = op[5] ? ~a : a;
    y = op[6] ? ~b : b;
    bb = (f == 4'd9) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{n{1'b0}}, cin};
    big = b >= n_val;
    asr = $signed(a) >>> b;
    rot = b % n_val;
    rol = (a << rot) | (a >> (n_val - rot));
    ror = (a >> rot) | (a << (n_val - rot));
    s_lo = '0;
    s_hi = '0;
    s_c = 1'b0;
    s_v = 1'b0;
    s_dz = 1'b0;
    case (f)
      4'd0: s_lo = x & y;
      4'd1: s_lo = x | y;
      4'd2: s_lo = x ^ y;
      4'd3: s_lo = ~x;
      4'd4: s_lo = big ? '0 : a >> b;
      4'd5: s_lo = big ? '0 : a << b;
      4'd6: s_lo = big ? {n{a[n-1]}} : asr;
      4'd9, 4'd10: begin
        s_lo = sum[n-1:0];
        s_c = sum[n];
        s_v = (a[n-1] == bb[n-1]) & (sum[n-1] != a[n-1]);
      end
      4'd11: s_lo = rol;
      4'd12: s_lo = ror;
      4'd13: begin
        s_lo = '1;
        s_hi = a;
        s_dz = 1'b1;
      end
      4'd14: begin
        s_lo = a;
        s_hi = '1;
        s_dz = 1'b1;
      end
      default: s_lo = '0;
    endcase
    s_out = (f == 4'd15) ? '0 : s_lo ^ {n{op[4]}};
    s_zero = (f != 4'd15) & ~|s_out;
  end
  // one shift-add (mul) or restoring shift-subtract (div) step, plus the final result
  always_comb begin
    is_mul = (f_r == 4'd7) | (f_r == 4'd8);
    msum = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
    t = {acc, q[n-1]};
    ge = t >= {1'b0, d};
    td = t[n-1:0] - d;
    nacc = is_mul ? msum[n:1] : (ge ? td : t[n-1:0]);
    nq = is_mul ? {msum[0], q[n-1:1]} : {q[n-2:0], ge};
    prod = neg_r ? -{nacc, nq} : {nacc, nq};
    f_lo = is_mul ? prod[n-1:0] : ((f_r == 4'd13) ? nq : nacc);
    f_hi = is_mul ? prod[2*n-1:n] : ((f_r == 4'd13) ? nacc : nq);
    f_v = (f_r == 4'd7) ? |prod[2*n-1:n] : (f_r == 4'd8) & (prod[2*n-1:n] != {n{prod[n-1]}});
    f_out = f_lo ^ {n{inv_r}};
  end
  // handshake FSM, iteration engine and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= st_idle;
      cnt <= '0;
      f_r <= '0;
      inv_r <= 1'b0;
      neg_r <= 1'b0;
      acc <= '0;
      q <= '0;
      d <= '0;
      out_valid <= 1'b0;
      out <= '0;
      out_hi <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      sign <= 1'b0;
      zero <= 1'b0;
      div_zero <= 1'b0;
    end else if (take && iter) begin
      st <= st_busy;
      cnt <= '0;
      out_valid <= 1'b0;
      f_r <= f;
      inv_r <= op[4];
      neg_r <= (f == 4'd8) & (a[n-1] ^ b[n-1]);
      acc <= '0;
      q <= in_mul ? mb : a;
      d <= in_mul ? ma : b;
    end else if (take) begin
      st <= st_done;
      out_valid <= 1'b1;
      out <= s_out;
      out_hi <= s_hi;
      cout <= s_c;
      overflow <= s_v;
      sign <= s_out[n-1];
      zero <= s_zero;
      div_zero <= s_dz;
    end else if (st == st_busy) begin
      acc <= nacc;
      q <= nq;
      cnt <= cnt + 1'b1;
      if (cnt == last_cnt) begin
        st <= st_done;
        out_valid <= 1'b1;
        out <= f_out;
        out_hi <= f_hi;
        cout <= 1'b0;
        overflow <= f_v;
        sign <= f_out[n-1];
        zero <= ~|f_out;
        div_zero <= 1'b0;
      end
    end else if ((st == st_done) && out_ready) begin
      st <= st_idle;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with an arithmetic reference model
module tb_alu_seq;
  localparam int n = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic [n-1:0] a = '0, b = '0;
  logic [6:0] op = '0;
  logic in_ready, out_valid, cout, overflow, sign, zero, div_zero;
  logic [n-1:0] out, out_hi;
  int errors = 0, checks = 0;
  typedef struct packed {logic [7:0] lo; logic [7:0] hi; logic c, v, s, z, dz;} res_t;
  res_t exp_r, pend_r;
  logic exp_valid = 1'b0;
  int pend_cnt = 0;

  alu_seq #(.n(n)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .cout(cout), .overflow(overflow), .sign(sign),
    .zero(zero), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [6:0] o, input logic [7:0] xa, input logic [7:0] xb, input logic ci);
    int ua, ub, sa, sb, la, lb, p, r, lo, hi;
    res_t res;
    res = '0;
    ua = int'(xa);
    ub = int'(xb);
    sa = xa[7] ? ua - 256 : ua;
    sb = xb[7] ? ub - 256 : ub;
    la = o[5] ? 255 - ua : ua;
    lb = o[6] ? 255 - ub : ub;
    lo = 0;
    hi = 0;
    case (o[3:0])
      4'd0: lo = la & lb;
      4'd1: lo = la | lb;
      4'd2: lo = la ^ lb;
      4'd3: lo = 255 - la;
      4'd4: lo = (ub >= 8) ? 0 : ua >> ub;
      4'd5: lo = (ub >= 8) ? 0 : (ua << ub) & 255;
      4'd6: lo = (ub >= 8) ? (xa[7] ? 255 : 0) : (sa >>> ub) & 255;
      4'd7: begin p = ua * ub; lo = p & 255; hi = (p >> 8) & 255; res.v = p > 255; end
      4'd8: begin p = sa * sb; lo = p & 255; hi = (p >> 8) & 255; res.v = (p > 127) || (p < -128); end
      4'd9: begin p = ua + (255 - ub) + int'(ci); lo = p & 255; res.c = p > 255; r = sa - sb - 1 + int'(ci); res.v = (r > 127) || (r < -128); end
      4'd10: begin p = ua + ub + int'(ci); lo = p & 255; res.c = p > 255; r = sa + sb + int'(ci); res.v = (r > 127) || (r < -128); end
      4'd11: begin r = ub % 8; lo = ((ua << r) | (ua >> (8 - r))) & 255; end
      4'd12: begin r = ub % 8; lo = ((ua >> r) | (ua << (8 - r))) & 255; end
      4'd13: if (ub == 0) begin lo = 255; hi = ua; res.dz = 1'b1; end else begin lo = ua / ub; hi = ua % ub; end
      4'd14: if (ub == 0) begin lo = ua; hi = 255; res.dz = 1'b1; end else begin lo = ua % ub; hi = ua / ub; end
      default: return '0;
    endcase
    if (o[4]) lo = 255 - lo;
    res.lo = 8'(lo);
    res.hi = 8'(hi);
    res.s = lo >= 128;
    res.z = lo == 0;
    return res;
  endfunction

  function automatic bit iterative(input logic [6:0] o, input logic [7:0] xb);
    return (o[3:0] == 4'd7) || (o[3:0] == 4'd8) || (((o[3:0] == 4'd13) || (o[3:0] == 4'd14)) && xb != 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid = 1'b0;
      pend_cnt = 0;
    end else begin
      bit rdy;
      rdy = (pend_cnt == 0) && (!exp_valid || out_ready);
      if (exp_valid && out_ready) exp_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          exp_valid = 1'b1;
          exp_r = pend_r;
        end
      end
      if (in_valid && rdy) begin
        if (iterative(op, b)) begin
          pend_r = model(op, a, b, cin);
          pend_cnt = n;
        end else begin
          exp_r = model(op, a, b, cin);
          exp_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic model_rdy;
      logic [20:0] got;
      model_rdy = (pend_cnt == 0) && (!exp_valid || out_ready);
      checks++;
      if (out_valid !== exp_valid) begin errors++; $display("FAIL out_valid: got %b expected %b", out_valid, exp_valid); end
      checks++;
      if (in_ready !== model_rdy) begin errors++; $display("FAIL in_ready: got %b expected %b", in_ready, model_rdy); end
      if (exp_valid) begin
        got = {out, out_hi, cout, overflow, sign, zero, div_zero};
        checks++;
        if (got !== exp_r) begin errors++; $display("FAIL result: got %h expected %h", got, exp_r); end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic issue(input logic [6:0] o, input logic [7:0] xa, input logic [7:0] xb, input logic ci, output int tries);
    bit got_it;
    got_it = 1'b0;
    tries = 0;
    op = o;
    a = xa;
    b = xb;
    cin = ci;
    in_valid = 1'b1;
    while (!got_it && tries < 60) begin
      @(negedge clk);
      got_it = in_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    a = 8'hA5;
    b = 8'h5A;
    op = 7'h0A;
    if (!got_it) chk("accept_timeout", 32'(tries), 32'(1));
  endtask

  task automatic wait_out(output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      seen = out_valid;
      if (!seen) @(posedge clk);
    end
    if (!seen) chk("result_timeout", 32'(lat), 32'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [6:0] o, input logic [7:0] xa, input logic [7:0] xb, input logic ci);
    int t, l;
    issue(o, xa, xb, ci, t);
    wait_out(l);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int t, lat;
    logic [7:0] held;
    repeat (3) step();
    chk("rst_outputs", {out, out_hi, cout, overflow, sign, zero, div_zero, out_valid}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();
    issue(7'd10, 8'h7F, 8'h01, 1'b0, t);
    wait_out(lat);
    chk("add_latency", lat, 1);
    chk("add_out", out, 8'h80);
    chk("add_flags", {cout, overflow, sign, zero}, 4'b0110);
    step();
    issue(7'd8, 8'hFE, 8'h03, 1'b0, t);
    wait_out(lat);
    chk("smul_latency", lat, 9);
    chk("smul_prod", {out_hi, out}, 16'hFFFA);
    chk("smul_ovf", overflow, 0);
    step();
    issue(7'd13, 8'd200, 8'd7, 1'b0, t);
    wait_out(lat);
    chk("div_qr", {out, out_hi}, {8'd28, 8'd4});
    step();
    issue(7'd13, 8'd200, 8'd0, 1'b0, t);
    wait_out(lat);
    chk("div0_latency", lat, 1);
    chk("div0_res", {out, out_hi, div_zero}, {8'hFF, 8'd200, 1'b1});
    step();
    issue(7'd6, 8'h80, 8'd9, 1'b0, t);
    wait_out(lat);
    chk("asr_big", out, 8'hFF);
    step();
    issue(7'd5, 8'h01, 8'd8, 1'b0, t);
    wait_out(lat);
    chk("lsl_big", {out, zero}, {8'h00, 1'b1});
    step();
    issue(7'd12, 8'h01, 8'd9, 1'b0, t);
    wait_out(lat);
    chk("ror_wrap", out, 8'h80);
    step();
    run(7'h20, 8'h0F, 8'h3C, 1'b0);
    run(7'h12, 8'hAA, 8'h0F, 1'b0);
    run(7'h43, 8'h5A, 8'h00, 1'b0);
    run(7'd9, 8'h05, 8'h07, 1'b1);
    run(7'd9, 8'h80, 8'h01, 1'b1);
    run(7'd10, 8'hFF, 8'h00, 1'b1);
    run(7'd4, 8'hF0, 8'd3, 1'b0);
    run(7'd6, 8'hC4, 8'd2, 1'b0);
    run(7'd11, 8'h81, 8'd3, 1'b0);
    run(7'd7, 8'hFF, 8'hFF, 1'b0);
    run(7'd8, 8'h80, 8'h80, 1'b0);
    run(7'd8, 8'h00, 8'hFB, 1'b0);
    run(7'h17, 8'h10, 8'h03, 1'b0);
    run(7'd14, 8'd200, 8'd7, 1'b0);
    run(7'd14, 8'd9, 8'd0, 1'b0);
    run(7'h1F, 8'h33, 8'h44, 1'b1);
    issue(7'd10, 8'd1, 8'd2, 1'b0, t);
    for (int i = 0; i < 3; i++) begin
      issue(7'd10, 8'(i), 8'd10, 1'b1, t);
      chk("b2b_accept", t, 1);
    end
    step();
    out_ready = 1'b0;
    issue(7'd10, 8'd3, 8'd4, 1'b0, t);
    wait_out(lat);
    held = out;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("bp_hold", out, 8'd7);
      chk("bp_ready", in_ready, 0);
    end
    step();
    out_ready = 1'b1;
    issue(7'd10, 8'd10, 8'd20, 1'b0, t);
    chk("bp_accept", t, 1);
    wait_out(lat);
    chk("bp_next_lat", lat, 1);
    chk("bp_next_out", out, 8'd30);
    step();
    issue(7'd7, 8'h12, 8'h34, 1'b0, t);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_out", {out, out_hi}, 0);
    chk("rst_mid_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    issue(7'd7, 8'h12, 8'h34, 1'b0, t);
    wait_out(lat);
    chk("mul_after_rst_lat", lat, 9);
    chk("mul_after_rst", {out_hi, out}, 16'h03A8);
    step();
    issue(7'd13, 8'd255, 8'd16, 1'b0, t);
    op = 7'd10;
    a = 8'd1;
    b = 8'd1;
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    wait_out(lat);
    chk("busy_ignore", {out, out_hi}, {8'd15, 8'd15});
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
